// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_resp_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Misaligned, below the window, or past the last word.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input logic [WORD_W-1:0] base,
                                    input int unsigned       depth);
    logic [WORD_W-1:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= WORD_W'(depth));
  endfunction

endpackage

// File: rtl/dmem_responder_be_ram.sv
// Single-port word RAM with per-byte write enables and registered read.
module be_ram
  import dmem_resp_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 64,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Req/ack data-memory responder with programmable wait states, byte enables
// and address error reporting.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 64,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              bad_q, bad_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              rd_ok_q, rd_ok_d;

  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign req_idx = AW'((addr_i - BASE_ADDR) >> 2);

  // In IDLE the RAM is pointed at the incoming address so a zero-wait read
  // has its data ready on entry to RESP.
  assign ram_addr = (state_q == IDLE) ? req_idx : idx_q;
  assign ram_we   = (state_q == RESP) && we_q && !bad_q;

  be_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .be_i   (be_q),
    .addr_i (ram_addr),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_ok_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          bad_d   = addr_err(addr_i, BASE_ADDR, DEPTH_WORDS);
          idx_d   = req_idx;
          wdata_d = wdata_i;
          be_d    = be_i;
          busy_d  = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Response flags are registered on the edge that enters RESP.
    if ((state_d == RESP) && (state_q != RESP)) begin
      ack_d   = 1'b1;
      err_d   = bad_d;
      rd_ok_d = !we_d && !bad_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;
  assign rdata_o = rd_ok_q ? ram_rdata : '0;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the processor's data port. It accepts word read/write requests over a req/ack handshake and models a data RAM with programmable wait states, byte enables and error signalling. It sits between the processor core (initiator) and the system's backing storage, and replaces the zero-latency combinational data memory for multi-cycle memory timing.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in storage; power of two, at least 4
WAIT_CYCLES, 2, wait states inserted between request accept and ack; 0 to 15
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req  in  1  request valid; held high by the initiator until ack
we  in  1  1 = write, 0 = read; sampled at accept
addr  in  32  byte address; sampled at accept
wdata  in  32  write data; sampled at accept
be  in  4  byte enables, be[i] covers wdata[8i+7:8i]; sampled at accept
ack  out  1  one-cycle completion pulse
rdata  out  32  read data; valid only while ack=1
err  out  1  error flag; valid only while ack=1
busy  out  1  high from the accepting edge until the edge that ends ack

Behaviour:
- Reset, asynchronous, reset=0: state=IDLE, ack=0, err=0, rdata=0, busy=0, wait counter=0, latched request registers=0.
- Storage array contents are not cleared by reset.
- FSM states:
  - IDLE: if req=1, latch we/addr/wdata/be and set busy=1. Go to WAIT if WAIT_CYCLES>0, otherwise to RESP.
  - WAIT: count down from WAIT_CYCLES-1. Go to RESP at the edge where the count equals 0.
  - RESP: ack=1 for exactly one cycle, then return to IDLE.
- Latency: if req first rises in cycle N while in IDLE, ack is high in cycle N+1+WAIT_CYCLES.
- Inputs are ignored outside IDLE. Changing addr/wdata/we/be, or dropping req, mid-transaction has no effect.
- A dropped req does not abort the transaction; it completes with ack as normal.
- Back-to-back: if req is still high in the IDLE cycle after RESP, that is a new request. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- Address decode: word index = (addr - BASE_ADDR) >> 2.
- err=1 if addr[1:0]!=0, or if addr < BASE_ADDR, or if index >= DEPTH_WORDS.
- On err=1: no write occurs and rdata=0.
- Write (we=1, err=0):
  - Bytes whose be bit is 1 are updated at the rising edge that ends the RESP cycle.
  - be=4'b0000 is legal: ack is given and nothing is written.
  - rdata=0 during a write ack.
- Read (we=1 ignored, we=0, err=0): rdata = stored word, registered into RESP. be is ignored on reads.
- Read-after-write to the same address in the next transaction returns the new data.
- Reset asserted mid-transaction: the transaction is abandoned, no ack is issued, no write occurs. An in-flight write becomes visible only if RESP completed before reset.
- All outputs are registered. There is no combinational path from req to ack.

Decomposition:
- Package dmem_resp_pkg contains:
  - state enum: IDLE, WAIT, RESP
  - WORD_W=32 and BE_W=4
  - an address-check function that returns the err condition
- One sub-module, be_ram:
  - synchronous single-port word array with 4-bit byte-enable write and synchronous read
  - parameterised by DEPTH_WORDS
  - no reset

Test Plan:
- Reset, then write addr=0x10, wdata=0xDEADBEEF, be=4'hF, WAIT_CYCLES=2, req rises in cycle 5 -> ack high in cycle 8 only, err=0, busy high in cycles 6-8.
- Read addr=0x10 after the previous write -> ack after 3 cycles, rdata=0xDEADBEEF, err=0.
- Partial write addr=0x10, wdata=0x00001122, be=4'b0011, then read 0x10 -> rdata=0xDEAD1122.
- Misaligned read addr=0x13 -> ack with err=1, rdata=0. Out-of-range write addr=0x100 with DEPTH_WORDS=64 -> err=1, and a later read of 0x0 is unchanged.
- req held high continuously with WAIT_CYCLES=0 -> ack pulses every 2nd cycle. Altering addr while busy has no effect on the returned data.
- reset driven 0 during WAIT of a write to 0x20 (prior value 0x0), released, then read 0x20 -> no ack during the aborted transaction, all outputs 0 immediately on reset, readback 0x00000000.
